cpu_mc_ctrl: RTL and testbench

CPU_MC_CTRL -- requirements
Module: cpu_mc_ctrl

---
 rtl/cpu_mc_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cpu_mc_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc_ctrl.sv
// Multicycle CPU control FSM with a bounded data-memory wait and a sticky error trap.
// Define CPU_MC_PERF_EN to build the retired/cycles performance counters.
module cpu_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins_onehot,
  input  logic        dm_ready,
  input  logic        halt_req,
  output logic        ir_en,
  output logic        pc_en,
  output logic        rf_w_en,
  output logic        dm_req,
  output logic        dm_we,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic [31:0] cycles
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_BR,
    C_JAL,
    C_LW,
    C_SW
  } cls_e;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q;
  cls_e       cls_q;
  cls_e       decCls;
  logic       rstExit_q;
  logic       irEn_q;
  logic       pcEn_q;
  logic       rfWEn_q;
  logic       dmReq_q;
  logic       dmWe_q;
  logic [7:0] waitCnt_q;

  always_comb begin
    decCls = C_ALU;
    if (ins_onehot[22])      decCls = C_LW;
    else if (ins_onehot[23]) decCls = C_SW;
    else if (ins_onehot[30]) decCls = C_JAL;
    else if (ins_onehot[16] | ins_onehot[24] | ins_onehot[25] | ins_onehot[29]) decCls = C_BR;
  end

  // Strobes are registered for the state being entered. halt_req is sampled on
  // the edge that enters FETCH, so a halting FETCH never raises ir_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ALU;
      rstExit_q <= 1'b1;
      irEn_q    <= 1'b0;
      pcEn_q    <= 1'b0;
      rfWEn_q   <= 1'b0;
      dmReq_q   <= 1'b0;
      dmWe_q    <= 1'b0;
      waitCnt_q <= 8'd0;
    end else begin
      irEn_q  <= 1'b0;
      pcEn_q  <= 1'b0;
      rfWEn_q <= 1'b0;
      dmReq_q <= 1'b0;
      dmWe_q  <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (rstExit_q) begin
            rstExit_q <= 1'b0;
            irEn_q    <= ~halt_req;
          end else if (irEn_q) begin
            state_q <= S_DECODE;
          end else begin
            state_q <= S_HALT;
          end
        end
        S_DECODE: begin
          if (!$onehot(ins_onehot)) begin
            state_q <= S_ERR;
          end else begin
            cls_q   <= decCls;
            state_q <= S_EXEC;
            pcEn_q  <= (decCls == C_BR) || (decCls == C_JAL);
            rfWEn_q <= (decCls == C_JAL);
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_ALU: begin
              state_q <= S_WB;
              pcEn_q  <= 1'b1;
              rfWEn_q <= 1'b1;
            end
            C_BR, C_JAL: begin
              state_q <= S_FETCH;
              irEn_q  <= ~halt_req;
            end
            C_LW, C_SW: begin
              state_q   <= S_MEM;
              dmReq_q   <= 1'b1;
              dmWe_q    <= (cls_q == C_SW);
              waitCnt_q <= 8'd0;
            end
            default: state_q <= S_ERR;
          endcase
        end
        S_MEM: begin
          // A ready on the final allowed wait cycle wins over the timeout.
          if (dm_ready) begin
            if (cls_q == C_LW) begin
              state_q <= S_WB;
              pcEn_q  <= 1'b1;
              rfWEn_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              pcEn_q  <= 1'b1;
              irEn_q  <= ~halt_req;
            end
          end else if (waitCnt_q == WAIT_LAST) begin
            state_q <= S_ERR;
          end else begin
            waitCnt_q <= waitCnt_q + 8'd1;
            dmReq_q   <= 1'b1;
            dmWe_q    <= (cls_q == C_SW);
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          irEn_q  <= ~halt_req;
        end
        S_HALT: begin
          if (!halt_req) begin
            state_q <= S_FETCH;
            irEn_q  <= 1'b1;
          end
        end
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_ERR;
      endcase
    end
  end

  assign ir_en   = irEn_q;
  assign pc_en   = pcEn_q;
  assign rf_w_en = rfWEn_q;
  assign dm_req  = dmReq_q;
  assign dm_we   = dmWe_q;
  assign state   = state_q;
  assign err     = (state_q == S_ERR);
  assign busy    = (state_q != S_HALT) && (state_q != S_ERR);

`ifdef CPU_MC_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 32'd0;
      cycles_q  <= 32'd0;
    end else begin
      if (busy)   cycles_q  <= cycles_q + 32'd1;
      if (pcEn_q) retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
  assign cycles  = cycles_q;
`else
  assign retired = 32'd0;
  assign cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Self-checking bench for cpu_mc_ctrl: directed scenarios plus randomized instruction
// streams compared against a per-instruction cycle schedule built from the latency rules.
module tb_cpu_mc_ctrl;

  localparam int TIMEOUT = 15;
`ifdef CPU_MC_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] ins_onehot;
  logic        dm_ready;
  logic        halt_req;
  logic        ir_en;
  logic        pc_en;
  logic        rf_w_en;
  logic        dm_req;
  logic        dm_we;
  logic        busy;
  logic        err;
  logic [2:0]  state;
  logic [31:0] retired;
  logic [31:0] cycles;

  int          checkCount = 0;
  int          passCount  = 0;
  int          failCount  = 0;
  logic [31:0] expCycles  = 32'd0;
  logic [31:0] expRetired = 32'd0;
  bit          pendPc     = 1'b0;

  cpu_mc_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_onehot (ins_onehot),
    .dm_ready   (dm_ready),
    .halt_req   (halt_req),
    .ir_en      (ir_en),
    .pc_en      (pc_en),
    .rf_w_en    (rf_w_en),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .busy       (busy),
    .err        (err),
    .state      (state),
    .retired    (retired),
    .cycles     (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the inputs sampled by the next rising edge, then move to the next sample point.
  task automatic applyStimulus(input bit ready, input bit halt);
    dm_ready = ready;
    halt_req = halt;
    @(negedge clk);
  endtask

  task automatic expectCycle(input string tag, input int st, input bit ir, input bit pc,
                             input bit rf, input bit req, input bit we);
    checkOutput({tag, ".state"},   32'(state),   32'(st));
    checkOutput({tag, ".ir_en"},   32'(ir_en),   32'(ir));
    checkOutput({tag, ".pc_en"},   32'(pc_en),   32'(pc));
    checkOutput({tag, ".rf_w_en"}, 32'(rf_w_en), 32'(rf));
    checkOutput({tag, ".dm_req"},  32'(dm_req),  32'(req));
    checkOutput({tag, ".dm_we"},   32'(dm_we),   32'(we));
    checkOutput({tag, ".busy"},    32'(busy),    32'(st != 5 && st != 6));
    checkOutput({tag, ".err"},     32'(err),     32'(st == 6));
    checkOutput({tag, ".retired"}, retired, PERF ? expRetired : 32'd0);
    checkOutput({tag, ".cycles"},  cycles,  PERF ? expCycles  : 32'd0);
    if (st != 5 && st != 6) expCycles++;
    if (pc) expRetired++;
  endtask

  function automatic int classOf(input int bitIdx);
    case (bitIdx)
      16, 24, 25, 29: return 1;
      30:             return 2;
      22:             return 3;
      23:             return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit noise();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic doReset();
    rst        = 1'b1;
    dm_ready   = 1'b0;
    halt_req   = 1'b0;
    ins_onehot = 32'd0;
    @(negedge clk);
    checkOutput("reset.state",   32'(state),   32'd0);
    checkOutput("reset.ir_en",   32'(ir_en),   32'd0);
    checkOutput("reset.pc_en",   32'(pc_en),   32'd0);
    checkOutput("reset.rf_w_en", 32'(rf_w_en), 32'd0);
    checkOutput("reset.dm_req",  32'(dm_req),  32'd0);
    checkOutput("reset.err",     32'(err),     32'd0);
    checkOutput("reset.retired", retired, 32'd0);
    checkOutput("reset.cycles",  cycles,  32'd0);
    rst        = 1'b0;
    expCycles  = 32'd1;
    expRetired = 32'd0;
    pendPc     = 1'b0;
    @(negedge clk);
  endtask

  // One instruction from its FETCH to the following FETCH (or through a halt).
  task automatic runInstr(input int bitIdx, input int waits, input bit haltAfter, input int haltCycles);
    int  cls;
    bit  isBr;
    cls        = classOf(bitIdx);
    isBr       = (cls == 1) || (cls == 2);
    ins_onehot = 32'd1 << bitIdx;
    expectCycle("fetch", 0, 1'b1, pendPc, 1'b0, 1'b0, 1'b0);
    pendPc = 1'b0;
    applyStimulus(noise(), 1'b0);
    expectCycle("decode", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(noise(), noise());
    expectCycle("exec", 2, 1'b0, isBr, cls == 2, 1'b0, 1'b0);
    applyStimulus(noise(), isBr ? haltAfter : noise());
    if (cls >= 3) begin
      for (int k = 0; k <= waits; k++) begin
        expectCycle("mem", 3, 1'b0, 1'b0, 1'b0, 1'b1, cls == 4);
        applyStimulus(k == waits, (k == waits && cls == 4) ? haltAfter : noise());
      end
      if (cls == 4) pendPc = 1'b1;
    end
    if (cls == 0 || cls == 3) begin
      expectCycle("wb", 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(noise(), haltAfter);
    end
    if (haltAfter) begin
      expectCycle("fetchHalt", 0, 1'b0, pendPc, 1'b0, 1'b0, 1'b0);
      pendPc = 1'b0;
      applyStimulus(noise(), 1'b1);
      for (int j = 0; j < haltCycles; j++) begin
        expectCycle("halt", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(noise(), j < haltCycles - 1);
      end
    end
  endtask

  task automatic expectErrCycles(input int n);
    for (int j = 0; j < n; j++) begin
      expectCycle("err", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(noise(), noise());
    end
  endtask

  task automatic runDecodeErr(input logic [31:0] badIns);
    ins_onehot = badIns;
    expectCycle("badFetch", 0, 1'b1, pendPc, 1'b0, 1'b0, 1'b0);
    pendPc = 1'b0;
    applyStimulus(1'b0, 1'b0);
    expectCycle("badDecode", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectErrCycles(3);
  endtask

  initial begin
    rst        = 1'b1;
    dm_ready   = 1'b0;
    halt_req   = 1'b0;
    ins_onehot = 32'd0;
    @(negedge clk);

    doReset();
    runInstr(0, 0, 1'b0, 0);
    runInstr(22, 3, 1'b0, 0);
    runInstr(30, 0, 1'b1, 3);
    runInstr(23, 0, 1'b0, 0);
    runInstr(22, TIMEOUT - 1, 1'b0, 0);
    runInstr(24, 0, 1'b0, 0);

    repeat (40) begin
      runInstr($urandom_range(0, 31), $urandom_range(0, 4),
               $urandom_range(0, 3) == 0, $urandom_range(1, 3));
    end

    // Reset while a load is waiting in MEM.
    ins_onehot = 32'd1 << 22;
    expectCycle("rstMem.fetch", 0, 1'b1, pendPc, 1'b0, 1'b0, 1'b0);
    pendPc = 1'b0;
    applyStimulus(1'b0, 1'b0);
    expectCycle("rstMem.decode", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycle("rstMem.exec", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycle("rstMem.mem", 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    doReset();

    // Store that never completes traps after TIMEOUT MEM cycles.
    ins_onehot = 32'd1 << 23;
    expectCycle("to.fetch", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycle("to.decode", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycle("to.exec", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < TIMEOUT; k++) begin
      expectCycle("to.mem", 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, noise());
    end
    expectErrCycles(4);
    doReset();

    runDecodeErr(32'h0000_0003);
    doReset();
    runInstr(5, 0, 1'b0, 0);
    runDecodeErr(32'h0000_0000);
    doReset();
    runInstr(29, 0, 1'b0, 0);
    expectCycle("final.fetch", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
